// File: rtl/seq_dect_pkg.sv
// seq_dect_pkg
//   Shared definitions for the sequence-detector family.
//   - seq_state_e : detector FSM state encoding
//   - len_w()     : width needed to hold a pattern length 0..max_len
package seq_dect_pkg;

  typedef enum logic {
    ST_UNCFG = 1'b0,
    ST_ARMED = 1'b1
  } seq_state_e;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_dect_win_cmp.sv
// seq_dect_win_cmp
//   Combinational window compare. Reports a hit when enough bits have been
//   seen and the newest i_len bits of the window equal the pattern.
//   Ports:
//     i_win  [MAX_LEN-1:0] candidate window, bit 0 = newest bit
//     i_pat  [MAX_LEN-1:0] pattern, bits >= i_len ignored
//     i_len  [LEN_W-1:0]   pattern length (0 never hits)
//     i_fill [LEN_W-1:0]   bits seen before the current one
//     o_hit                window matches
module seq_dect_win_cmp
  import seq_dect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] i_win,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [LEN_W-1:0]   i_fill,
  output logic               o_hit
);

  // One extra bit so that i_len == MAX_LEN still yields an all-ones mask.
  localparam logic [MAX_LEN:0] ONE = (MAX_LEN + 1)'(1);

  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_nxt;
  logic               w_full;
  logic               w_eq;

  assign w_mask     = MAX_LEN'((ONE << i_len) - ONE);
  assign w_fill_nxt = {1'b0, i_fill} + (LEN_W + 1)'(1);
  assign w_full     = (w_fill_nxt >= {1'b0, i_len});
  assign w_eq       = (((i_win ^ i_pat) & w_mask) == '0);
  assign o_hit      = w_full && w_eq && (i_len != '0);

endmodule

// File: rtl/seq_dect_prog.sv
// seq_dect_prog
//   Programmable serial pattern detector with overlap control and a
//   saturating match counter.
//   Ports:
//     i_clk, i_clr        clock, synchronous active-high reset
//     i_cfg_load          strobe: capture i_cfg_pat / i_cfg_len / i_cfg_overlap
//     i_cfg_pat/len/overlap  configuration (len valid 1..MAX_LEN)
//     i_din, i_din_vld    serial data and its qualifier
//     i_cnt_clr           clear match counter (wins over increment)
//     o_armed             valid configuration held
//     o_match             one-cycle pulse per detected pattern
//     o_match_cnt         saturating match count
//     o_cfg_err           one-cycle pulse on a rejected load
//
//   state    | meaning
//   ST_UNCFG | no valid configuration, input stream ignored
//   ST_ARMED | configured, matching accepted bits
module seq_dect_prog
  import seq_dect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pat,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_din,
  input  logic               i_din_vld,
  input  logic               i_cnt_clr,
  output logic               o_armed,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  seq_state_e         r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  // The oldest history bit is shifted out before it can reach the window,
  // so only MAX_LEN-1 bits are stored.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [MAX_LEN-1:0] w_win;
  logic               w_cmp_hit;
  logic               w_accept;
  logic               w_hit;
  logic               w_cfg_ok;
  logic [LEN_W-1:0]   w_fill_inc;

  assign w_win      = {r_hist, i_din};
  assign w_accept   = (r_state == ST_ARMED) && i_din_vld && !i_cfg_load;
  assign w_hit      = w_accept && w_cmp_hit;
  assign w_cfg_ok   = (i_cfg_len != '0) && (i_cfg_len <= MAX_LEN_L);
  assign w_fill_inc = (r_fill == MAX_LEN_L) ? r_fill : r_fill + LEN_W'(1);

  seq_dect_win_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_win_cmp (
    .i_win  (w_win),
    .i_pat  (r_pat),
    .i_len  (r_len),
    .i_fill (r_fill),
    .o_hit  (w_cmp_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= ST_UNCFG;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_match <= w_hit;
      r_err   <= i_cfg_load && !w_cfg_ok;

      if (i_cfg_load) begin
        // A rejected load leaves state, history and config untouched.
        if (w_cfg_ok) begin
          r_state <= ST_ARMED;
          r_pat   <= i_cfg_pat;
          r_len   <= i_cfg_len;
          r_ovl   <= i_cfg_overlap;
          r_hist  <= '0;
          r_fill  <= '0;
        end
      end else if (w_accept) begin
        r_hist <= w_win[MAX_LEN-2:0];
        // Non-overlap mode forgets everything seen so far after a match.
        r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_inc;
      end

      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_hit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_armed     = (r_state == ST_ARMED);
  assign o_match     = r_match;
  assign o_match_cnt = r_cnt;
  assign o_cfg_err   = r_err;

endmodule
